// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with a sequenced clear.
// Define REGFILE_MP_BYPASS_EN for same-cycle write-through reads.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_RD*ADDR_W-1:0] i_rs_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rs_data,
  input  logic [ADDR_W-1:0]        i_rd_addr,
  input  logic                     i_rd_wren,
  input  logic [DATA_W-1:0]        i_rd_data,
  input  logic                     i_clear,
  output logic                     o_busy,
  output logic                     o_wr_drop
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] clr_idx;
  logic [ADDR_W-1:0] clr_idx_nx;
  logic              drop_nx;
  logic              wr_zero;
  logic              wr_ok;
  logic [DATA_W-1:0] mem [DEPTH];

  assign wr_zero = (ZERO_REG != 0) && (i_rd_addr == '0);
  assign wr_ok   = !i_reset && (state == READY) && i_rd_wren
                && !i_clear && !wr_zero;
  assign o_busy  = (state == CLEAR);

  always_comb begin
    state_nx   = state;
    clr_idx_nx = clr_idx;
    drop_nx    = 1'b0;
    case (state)
      CLEAR: begin
        clr_idx_nx = clr_idx + 1'b1;
        drop_nx    = i_rd_wren;
        if (clr_idx == '1) state_nx = READY;
      end
      READY: begin
        drop_nx = i_rd_wren && i_clear;
        if (i_clear) begin
          state_nx   = CLEAR;
          clr_idx_nx = '0;
        end
      end
      default: state_nx = CLEAR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= CLEAR;
      clr_idx   <= '0;
      o_wr_drop <= 1'b0;
    end else begin
      state     <= state_nx;
      clr_idx   <= clr_idx_nx;
      o_wr_drop <= drop_nx;
    end
  end

  // The array has no reset; only the clear sequence zeroes it.
  always_ff @(posedge i_clk) begin
    if (!i_reset && state == CLEAR)
      mem[clr_idx] <= '0;
    else if (wr_ok)
      mem[i_rd_addr] <= i_rd_data;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;

    assign ra = i_rs_addr[p*ADDR_W +: ADDR_W];

    always_comb begin
      rv = mem[ra];
      if (state == CLEAR || (ZERO_REG != 0 && ra == '0))
        rv = '0;
`ifdef REGFILE_MP_BYPASS_EN
      else if (wr_ok && ra == i_rd_addr)
        rv = i_rd_data;
`endif
    end

    assign o_rs_data[p*DATA_W +: DATA_W] = rv;
  end

endmodule
